// File: rtl/pio_event_poller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pio_event_poller                                              |
// | Purpose  : Shares one PIO slave port between a host master and a poller  |
// |            that drains the edge-capture register into an event FIFO.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pio_event_poller #(
  parameter int POLL_INTERVAL = 1000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        poll_enable,
  input  logic [2:0]  host_address,
  input  logic        host_chipselect,
  input  logic        host_write_n,
  input  logic [31:0] host_writedata,
  output logic [31:0] host_readdata,
  output logic        host_waitrequest,
  output logic [2:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic        evt_valid,
  output logic [7:0]  evt_data,
  input  logic        evt_ready
);

  localparam int                 c_ptr_w      = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w      = c_ptr_w + 1;
  localparam logic [15:0]        c_timer_last = 16'(POLL_INTERVAL - 1);
  localparam logic [2:0]         c_cap_addr   = 3'd3;
  localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOST_WR  = 3'd1,
    HOST_RD  = 3'd2,
    HOST_RDD = 3'd3,
    POLL_RD  = 3'd4,
    POLL_CHK = 3'd5,
    POLL_CLR = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [15:0]          r_timer;
  logic                 r_poll_pending;
  logic                 r_last_grant_host;
  logic [2:0]           r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rd_hold;
  logic [7:0]           r_cap;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;

  logic w_timer_expire;
  logic w_poll_req;
  logic w_grant_host;
  logic w_grant_poll;
  logic w_push;
  logic w_pop;

  assign w_timer_expire = poll_enable && (r_timer == c_timer_last);
  assign w_poll_req     = r_poll_pending && (r_count < c_depth);
  assign w_push         = (r_state == POLL_CLR);
  assign evt_valid      = (r_count != '0);
  assign w_pop          = evt_valid && evt_ready;
  assign evt_data       = evt_valid ? r_mem[r_rd_ptr] : 8'h00;

  // Round-robin: on a tie the side that did not win last time is granted.
  always_comb begin
    w_grant_host = 1'b0;
    w_grant_poll = 1'b0;
    if (r_state == IDLE) begin
      if (host_chipselect && w_poll_req) begin
        w_grant_host = !r_last_grant_host;
        w_grant_poll = r_last_grant_host;
      end else begin
        w_grant_host = host_chipselect;
        w_grant_poll = w_poll_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    pio_chipselect   = 1'b0;
    pio_write_n      = 1'b1;
    pio_address      = 3'd0;
    pio_writedata    = 32'h0;
    host_waitrequest = 1'b1;
    host_readdata    = r_rd_hold;
    case (r_state)
      IDLE: begin
        if (w_grant_host) begin
          w_next = host_write_n ? HOST_RD : HOST_WR;
        end else if (w_grant_poll) begin
          w_next = POLL_RD;
        end
      end
      HOST_WR: begin
        pio_chipselect   = 1'b1;
        pio_write_n      = 1'b0;
        pio_address      = r_addr;
        pio_writedata    = r_wdata;
        host_waitrequest = 1'b0;
        w_next           = IDLE;
      end
      HOST_RD: begin
        pio_chipselect = 1'b1;
        pio_address    = r_addr;
        w_next         = HOST_RDD;
      end
      HOST_RDD: begin
        host_waitrequest = 1'b0;
        host_readdata    = pio_readdata;
        w_next           = IDLE;
      end
      POLL_RD: begin
        pio_chipselect = 1'b1;
        pio_address    = c_cap_addr;
        w_next         = POLL_CHK;
      end
      POLL_CHK: begin
        w_next = (pio_readdata[7:0] != 8'h00) ? POLL_CLR : IDLE;
      end
      POLL_CLR: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = c_cap_addr;
        pio_writedata  = 32'h0000_00FF;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant_host <= 1'b0;
      r_addr            <= 3'd0;
      r_wdata           <= 32'h0;
      r_rd_hold         <= 32'h0;
      r_cap             <= 8'h00;
    end else begin
      if (w_grant_host) begin
        r_last_grant_host <= 1'b1;
        r_addr            <= host_address;
        r_wdata           <= host_writedata;
      end else if (w_grant_poll) begin
        r_last_grant_host <= 1'b0;
      end
      if (r_state == HOST_RDD) begin
        r_rd_hold <= pio_readdata;
      end
      if (r_state == POLL_CHK) begin
        r_cap <= pio_readdata[7:0];
      end
    end
  end

  // Expiry wins over the POLL_RD clear so a coincident expiration is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer        <= 16'd0;
      r_poll_pending <= 1'b0;
    end else begin
      if (!poll_enable || w_timer_expire) begin
        r_timer <= 16'd0;
      end else begin
        r_timer <= r_timer + 16'd1;
      end
      if (w_timer_expire) begin
        r_poll_pending <= 1'b1;
      end else if (r_state == POLL_RD) begin
        r_poll_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_cap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_event_poller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pio_event_poller                                           |
// | Purpose  : Bench for pio_event_poller with a behavioural 8-bit PIO slave. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pio_event_poller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        poll_enable = 1'b0;
  logic [2:0]  host_address = 3'd0;
  logic        host_chipselect = 1'b0;
  logic        host_write_n = 1'b1;
  logic [31:0] host_writedata = 32'h0;
  logic [31:0] host_readdata;
  logic        host_waitrequest;
  logic [2:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata = 32'h0;
  logic        evt_valid;
  logic [7:0]  evt_data;
  logic        evt_ready = 1'b0;

  pio_event_poller #(.POLL_INTERVAL(8), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .poll_enable(poll_enable),
    .host_address(host_address), .host_chipselect(host_chipselect),
    .host_write_n(host_write_n), .host_writedata(host_writedata),
    .host_readdata(host_readdata), .host_waitrequest(host_waitrequest),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_ready(evt_ready)
  );

  always #5 clk = ~clk;

  // Behavioural PIO: 0 data (in_port read / out_port write), 1 direction,
  // 2 irq mask, 3 edge capture (rising edges accumulate, write clears bits).
  logic [7:0] in_port = 8'h00, in_prev = 8'h00, out_port = 8'h00;
  logic [7:0] dir_reg = 8'h00, mask_reg = 8'h00, edge_cap = 8'h00;
  always @(posedge clk) begin
    in_prev <= in_port;
    case (pio_address)
      3'd0:    pio_readdata <= {24'h0, in_port};
      3'd1:    pio_readdata <= {24'h0, dir_reg};
      3'd2:    pio_readdata <= {24'h0, mask_reg};
      3'd3:    pio_readdata <= {24'h0, edge_cap};
      default: pio_readdata <= 32'h0;
    endcase
    if (pio_chipselect && !pio_write_n) begin
      case (pio_address)
        3'd0:    out_port <= pio_writedata[7:0];
        3'd1:    dir_reg  <= pio_writedata[7:0];
        3'd2:    mask_reg <= pio_writedata[7:0];
        default: ;
      endcase
    end
    if (pio_chipselect && !pio_write_n && pio_address == 3'd3)
      edge_cap <= (edge_cap & ~pio_writedata[7:0]) | (in_port & ~in_prev);
    else
      edge_cap <= edge_cap | (in_port & ~in_prev);
  end

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_poll_rd = 0;
  int   n_clr = 0;
  int   n_wr = 0;
  bit   evt_seen = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] m_dir = 8'h00, m_mask = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pio_chipselect && pio_write_n && pio_address == 3'd3) n_poll_rd++;
    if (pio_chipselect && !pio_write_n) n_wr++;
    if (pio_chipselect && !pio_write_n && pio_address == 3'd3) begin
      n_clr++;
      check("clear_writedata", pio_writedata, 32'h0000_00FF);
    end
    if (evt_valid) evt_seen = 1'b1;
  end

  // Host access; waits counts negedge samples with waitrequest high.
  task automatic host_xfer(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                           input logic hold, output logic [31:0] rd, output int waits);
    @(posedge clk); #1;
    host_chipselect = 1'b1;
    host_write_n    = !wr;
    host_address    = a;
    host_writedata  = wd;
    waits = 0;
    @(negedge clk);
    while (host_waitrequest && waits < 60) begin
      waits++;
      @(negedge clk);
    end
    rd = host_readdata;
    if (!hold) begin
      @(posedge clk); #1;
      host_chipselect = 1'b0;
      host_write_n    = 1'b1;
    end
  endtask

  task automatic pop_one();
    @(posedge clk); #1; evt_ready = 1'b1;
    @(posedge clk); #1; evt_ready = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    @(posedge clk); #1; in_port = m;
    @(posedge clk); #1; in_port = 8'h00;
  endtask

  task automatic wait_clear(input string tag, input int c0);
    int t;
    t = 0;
    while (n_clr == c0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(n_clr != c0), 32'd1);
  endtask

  task automatic produce(input int n);
    logic [7:0] m;
    int c0;
    for (int k = 0; k < n; k++) begin
      m  = 8'($urandom_range(1, 255));
      c0 = n_clr;
      exp_q.push_back(m);
      pulse(m);
      wait_clear("produce_cleared", c0);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
  endtask

  task automatic consume(input int n, input int ready_pct);
    int got, guard;
    logic [7:0] e;
    got = 0; guard = 0;
    while (got < n && guard < 4000) begin
      @(posedge clk); #1;
      evt_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if (evt_valid && evt_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        check("evt_data_order", {24'h0, evt_data}, {24'h0, e});
        got++;
      end
      guard++;
    end
    @(posedge clk); #1; evt_ready = 1'b0;
    check("consume_count", got, n);
  endtask

  task automatic host_random(input int n);
    logic [31:0] rd;
    int w, op;
    logic [7:0] v;
    logic [2:0] a;
    for (int k = 0; k < n; k++) begin
      op = $urandom_range(0, 3);
      v  = 8'($urandom);
      case (op)
        0: begin
          host_xfer(1'b1, 3'd0, {24'h0, v}, 1'b0, rd, w);
          check("rand_out_port", {24'h0, out_port}, {24'h0, v});
        end
        1: begin host_xfer(1'b1, 3'd1, {24'h0, v}, 1'b0, rd, w); m_dir = v; end
        2: begin host_xfer(1'b1, 3'd2, {24'h0, v}, 1'b0, rd, w); m_mask = v; end
        default: begin
          a = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd2;
          host_xfer(1'b0, a, 32'h0, 1'b0, rd, w);
          check("rand_rd_data", rd, {24'h0, (a == 3'd1) ? m_dir : m_mask});
        end
      endcase
      check("rand_wait_bound", 32'(w <= 6), 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  task automatic host_saturate(input int n);
    logic [31:0] rd;
    int w, maxw;
    maxw = 0;
    for (int k = 0; k < n; k++) begin
      host_xfer(1'b0, 3'd1, 32'h0, (k != n - 1), rd, w);
      check("sat_rd_data", rd, {24'h0, m_dir});
      if (w > maxw) maxw = w;
    end
    check("sat_max_wait", 32'(maxw <= 6), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int w, lat, c0, p0, wr0;
    bit found;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest", 32'(host_waitrequest), 32'd1);
    check("rst_readdata", host_readdata, 32'h0);
    check("rst_pio_cs", 32'(pio_chipselect), 32'd0);
    check("rst_pio_wn", 32'(pio_write_n), 32'd1);
    check("rst_pio_addr", 32'(pio_address), 32'd0);
    check("rst_pio_wd", pio_writedata, 32'h0);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_data", 32'(evt_data), 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    // Host passthrough with polling idle
    host_xfer(1'b1, 3'd0, 32'h0000_00A5, 1'b0, rd, w);
    check("pt_wr_wait", w, 1);
    check("pt_out_port", {24'h0, out_port}, 32'hA5);
    @(posedge clk); #1; in_port = 8'h3C;
    host_xfer(1'b0, 3'd0, 32'h0, 1'b0, rd, w);
    check("pt_rd_wait", w, 2);
    check("pt_rd_data", rd, 32'h0000_003C);
    in_port = 8'h00;
    @(negedge clk);
    check("pt_readdata_hold", host_readdata, 32'h0000_003C);

    // Capture left by the passthrough test drains once polling starts
    poll_enable = 1'b1;
    lat = 0;
    while (!evt_valid && lat < 40) begin @(negedge clk); lat++; end
    check("pt_evt_data", {24'h0, evt_data}, 32'h3C);
    pop_one();
    @(negedge clk);
    check("pt_evt_popped", 32'(evt_valid), 32'd0);

    // Event capture latency
    @(posedge clk); #1; in_port = 8'h04;
    lat = 0;
    @(posedge clk); #1; in_port = 8'h00;
    @(negedge clk); lat = 2;
    while (!evt_valid && lat < 40) begin @(negedge clk); lat++; end
    check("cap_latency_ok", 32'(lat <= 13), 32'd1);
    check("cap_evt_data", {24'h0, evt_data}, 32'h04);
    pop_one();
    host_xfer(1'b0, 3'd3, 32'h0, 1'b0, rd, w);
    check("cap_reg_cleared", rd, 32'h0);

    // Quiet inputs: polls happen but never write
    repeat (4) @(posedge clk);
    @(negedge clk);
    evt_seen = 1'b0; wr0 = n_wr; p0 = n_poll_rd;
    repeat (100) @(negedge clk);
    check("empty_no_writes", n_wr - wr0, 0);
    check("empty_no_events", 32'(evt_seen), 32'd0);
    check("empty_poll_count", 32'((n_poll_rd - p0) >= 11 && (n_poll_rd - p0) <= 13), 32'd1);

    // FIFO full: further captures are deferred, not dropped
    evt_ready = 1'b0;
    c0 = n_clr; pulse(8'h01); wait_clear("full_first_clear", c0);
    c0 = n_clr; pulse(8'h01); wait_clear("full_second_clear", c0);
    pulse(8'h0A);
    p0 = n_poll_rd;
    repeat (40) @(negedge clk);
    check("full_no_poll", n_poll_rd - p0, 0);
    check("full_head", {24'h0, evt_data}, 32'h01);
    c0 = n_clr;
    pop_one();
    @(negedge clk);
    check("full_after_pop1", {23'h0, evt_valid, evt_data}, {23'h0, 1'b1, 8'h01});
    wait_clear("deferred_clear", c0);
    @(negedge clk);
    pop_one();
    @(negedge clk);
    check("deferred_evt", {23'h0, evt_valid, evt_data}, {23'h0, 1'b1, 8'h0A});
    pop_one();
    @(negedge clk);
    check("full_drained", 32'(evt_valid), 32'd0);

    // Randomised traffic against the event queue and register model
    fork
      produce(12);
      consume(12, 50);
      host_random(30);
    join

    // Host saturating the port while polls keep arriving
    host_xfer(1'b1, 3'd1, 32'h0000_005A, 1'b0, rd, w);
    m_dir = 8'h5A;
    c0 = n_clr;
    fork
      host_saturate(30);
      produce(4);
      consume(4, 100);
    join
    check("sat_polls_served", n_clr - c0, 4);
    @(negedge clk);
    check("sat_readdata_hold", host_readdata, 32'h0000_005A);

    // Reset while a non-empty capture is being checked
    pulse(8'h80);
    found = 1'b0; lat = 0;
    while (!found && lat < 60) begin
      @(negedge clk);
      found = pio_chipselect && pio_write_n && (pio_address == 3'd3) && (edge_cap == 8'h80);
      lat++;
    end
    check("rstpoll_found_read", 32'(found), 32'd1);
    @(posedge clk); #1; reset = 1'b1;
    c0 = n_clr;
    @(negedge clk);
    @(negedge clk);
    check("rstpoll_waitreq", 32'(host_waitrequest), 32'd1);
    check("rstpoll_readdata", host_readdata, 32'h0);
    check("rstpoll_pio_bus", {pio_chipselect, pio_write_n, pio_address, pio_writedata},
          {1'b0, 1'b1, 3'd0, 32'h0});
    check("rstpoll_evt", {23'h0, evt_valid, evt_data}, 32'h0);
    repeat (3) @(negedge clk);
    check("rstpoll_no_clear", n_clr - c0, 0);
    check("rstpoll_cap_kept", {24'h0, edge_cap}, 32'h80);
    poll_enable = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
